mips_cpu_bus_ctrl: RTL and testbench
====================================

# mips_cpu_bus_ctrl

Avalon memory-mapped bus sequencer that shares the single CPU bus master port between the instruction-fetch requester and the load/store requester of the multicycle MIPS core. It arbitrates between the two, runs one transfer at a time, and holds bus signals stable under `waitrequest`. It also generates byte lanes for byte, halfword and word accesses, and returns aligned, extended read data to the core.

## Interface
- `FETCH_PRIORITY`, default 0: arbitration on simultaneous requests; 0 = data port wins, 1 = fetch port wins.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `f_req`  in  1  fetch request; held with `f_addr` until `f_ack`.
- `f_addr`  in  32  fetch byte address (word aligned).
- `f_ack`  out  1  one-cycle pulse: fetch complete, `f_rdata` valid.
- `f_rdata`  out  32  fetched instruction.
- `d_req`  in  1  data request; held with all `d_*` inputs until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address.
- `d_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `d_signed`  in  1  load sign-extends (LB/LH) when 1, zero-extends when 0.
- `d_wdata`  in  32  store data, right-justified.
- `d_ack`  out  1  one-cycle pulse: data access complete.
- `d_rdata`  out  32  load result, valid with `d_ack` (0 for stores).
- `d_err`  out  1  misaligned access flag, valid with `d_ack`.
- `busy`  out  1  high in any state other than IDLE.
- `address`  out  32  Avalon address, always `{addr[31:2],2'b00}`.
- `read`, `write`  out  1  Avalon strobes; never both high.
- `writedata`  out  32  Avalon write data.
- `byteenable`  out  4  Avalon byte lanes.
- `waitrequest`  in  1  slave stall.
- `readdata`  in  32  valid in the cycle `read`=1 and `waitrequest`=0.

## Operation
- States: IDLE, BUS, DONE.
- IDLE: sample `f_req`/`d_req`. On a request, latch the winning port's fields and load the bus registers; go to BUS. With no request, stay in IDLE.
- BUS: `read`/`write` asserted. While `waitrequest`=1, all Avalon outputs are held bit-stable.
- BUS with `waitrequest`=0:
  - On a read, capture `readdata`.
  - Drop the strobes and go to DONE.
- DONE: pulse the ack of the served port, with its data registered. Go to IDLE. Requests are never sampled in DONE.
- Losing requester stays pending; it is served on the next IDLE.
- Byte lanes (little-endian, a = `d_addr[1:0]`):
  - Byte: `byteenable` = 1<<a; `writedata` = `{4{wdata[7:0]}}`.
  - Half: `byteenable` = a[1] ? 1100 : 0011; `writedata` = `{2{wdata[15:0]}}`.
  - Word: `byteenable` = 1111; `writedata` = `wdata`.
- Fetch: always word access.
- Load: `readdata` >> (8*a), truncated to size, then sign- or zero-extended per `d_signed`. Half uses only a[1].
- Reset: on an edge with `rst`=1:
  - State goes to IDLE.
  - All outputs are 0 in the next cycle: `read`, `write`, acks, `d_err`, `busy`, `address`, `writedata`, `byteenable`, `f_rdata`, `d_rdata`.
  - An in-flight transfer is abandoned; no ack is issued for it.

## Timing
- Request in IDLE at cycle 0 → strobe cycles 1..1+W (W = `waitrequest`-high cycles) → ack in cycle 2+W.
- Minimum 3 cycles per access; one outstanding access.
- A requester may present a new request in the cycle after its ack.
- `busy` is 1 from cycle 1 through the ack cycle.

## Configuration
- `MIPS_BUS_ALIGN_CHECK_EN` defined:
  - A half access with a[0]=1, or a word access with a≠00, is misaligned.
  - It issues no bus cycle: IDLE→DONE, with `d_ack`=1, `d_err`=1, `d_rdata`=0.
- Undefined:
  - `d_err` is tied 0.
  - Low address bits are ignored per size: a word access uses the word-aligned address; a half access uses a[1] only.

## Test plan
- Fetch `f_addr`=0xBFC00000, `readdata`=0x24020005, no wait → cycle 1: `read`=1, `address`=0xBFC00000, `byteenable`=1111; cycle 2: `f_ack`=1, `f_rdata`=0x24020005.
- SW 0xDEADBEEF to 0x1004 with `waitrequest` high 3 cycles → `write` held 4 cycles with `writedata`/`address` stable; `d_ack` in cycle 5.
- `readdata`=0x80112233:
  - LB at 0x1003 → `byteenable`=1000, `d_rdata`=0xFFFFFF80.
  - LBU at 0x1003 → 0x00000080.
  - LHU at 0x1002 → `byteenable`=1100, 0x00008011.
- SB 0x000000AB at 0x1001 → `byteenable`=0010, `writedata`=0xABABABAB; SH 0x1234 at 0x1002 → 1100, 0x12341234.
- `f_req` and `d_req` raised in the same cycle, `FETCH_PRIORITY`=0 → data transfer first, `d_ack` at cycle 2, `f_ack` at cycle 5; with 1, order reversed.
- LW at 0x1002 → with macro: no strobe, `d_ack`=`d_err`=1 at cycle 1; without: `read` at 0x1000, `byteenable`=1111.
- `rst` asserted during `waitrequest` stall → all outputs 0 next cycle, no ack.

Source files
------------

// File: rtl/mips_cpu_bus_ctrl.sv
// mips_cpu_bus_ctrl
//   Shares the single Avalon-MM master port of the multicycle MIPS core
//   between the instruction-fetch requester and the load/store requester.
//   One transfer runs at a time (IDLE -> BUS -> DONE). Byte lanes and
//   replicated write data are generated for byte/half/word stores, and
//   loads come back shifted, truncated and sign/zero-extended.
//
//   Optional build macro:
//     MIPS_BUS_ALIGN_CHECK_EN - misaligned half/word data accesses complete
//     without a bus cycle, with d_err=1 and d_rdata=0. When undefined, the
//     low address bits a size does not use are ignored and d_err stays 0.
module mips_cpu_bus_ctrl #(
  parameter int unsigned FETCH_PRIORITY = 0  // 0: data wins a tie, 1: fetch wins
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        busy,
  // Avalon-MM master
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_DONE = 2'd2} state_e;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} size_e;

  // Encoding 11 behaves exactly like a word access.
  function automatic size_e norm_size(input logic [1:0] s);
    case (s)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  // Byte offset actually used by an access: half keeps only a[1], word none.
  function automatic logic [1:0] eff_lane(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return a;
      SZ_HALF: return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] lane);
    case (sz)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Right-justified store data replicated so every candidate lane carries it.
  function automatic logic [31:0] lane_data(input size_e sz, input logic [31:0] wd);
    case (sz)
      SZ_BYTE: return {4{wd[7:0]}};
      SZ_HALF: return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input size_e sz, input logic sgn,
                                           input logic [1:0] lane, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {lane, 3'b000};
    case (sz)
      SZ_BYTE: return {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: return {{16{sgn & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        serve_d_q, serve_d_d;   // 1: data port owns the current transfer
  size_e       size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  lane_q, lane_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] address_q, address_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        f_ack_q, f_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        d_err_q, d_err_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        busy_q, busy_d;

  size_e       req_size;
  logic [1:0]  req_lane;
  logic        d_wins;
  logic        bad_align;

  // Fetch addresses are word aligned; their low bits carry no information.
  logic        unused_f_addr_lo;
  assign unused_f_addr_lo = ^f_addr[1:0];

  // Data wins when fetch is idle or when data has priority on a tie.
  assign d_wins = d_req && (!f_req || (FETCH_PRIORITY == 0));

  // Misalignment detection exists only in the checking build.
`ifdef MIPS_BUS_ALIGN_CHECK_EN
  assign bad_align = ((norm_size(d_size) == SZ_HALF) && d_addr[0]) ||
                     ((norm_size(d_size) == SZ_WORD) && (d_addr[1:0] != 2'b00));
`else
  assign bad_align = 1'b0;
`endif

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    serve_d_d    = serve_d_q;
    size_d       = size_q;
    sign_d       = sign_q;
    lane_d       = lane_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    f_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;
    req_size     = norm_size(d_size);
    req_lane     = eff_lane(req_size, d_addr[1:0]);

    case (state_q)
      S_IDLE: begin
        if (d_wins) begin
          serve_d_d = 1'b1;
          size_d    = req_size;
          sign_d    = d_signed;
          lane_d    = req_lane;
          if (bad_align) begin
            // Rejected without touching the bus.
            state_d   = S_DONE;
            d_ack_d   = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            state_d      = S_BUS;
            address_d    = {d_addr[31:2], 2'b00};
            read_d       = !d_we;
            write_d      = d_we;
            byteenable_d = lane_mask(req_size, req_lane);
            writedata_d  = d_we ? lane_data(req_size, d_wdata) : '0;
          end
        end else if (f_req) begin
          serve_d_d    = 1'b0;
          size_d       = SZ_WORD;
          sign_d       = 1'b0;
          lane_d       = 2'b00;
          state_d      = S_BUS;
          address_d    = {f_addr[31:2], 2'b00};
          read_d       = 1'b1;
          write_d      = 1'b0;
          byteenable_d = 4'b1111;
          writedata_d  = '0;
        end
      end
      S_BUS: begin
        // Bus registers simply hold while the slave stalls.
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = S_DONE;
          if (serve_d_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = read_q ? load_ext(size_q, sign_q, lane_q, readdata) : '0;
          end else begin
            f_ack_d   = 1'b1;
            f_rdata_d = readdata;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; synchronous reset abandons any transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      serve_d_q    <= 1'b0;
      size_q       <= SZ_BYTE;
      sign_q       <= 1'b0;
      lane_q       <= 2'b00;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      f_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      serve_d_q    <= serve_d_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      lane_q       <= lane_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      f_ack_q      <= f_ack_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign read       = read_q;
  assign write      = write_q;
  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign f_ack      = f_ack_q;
  assign f_rdata    = f_rdata_q;
  assign d_ack      = d_ack_q;
  assign d_rdata    = d_rdata_q;
  assign d_err      = d_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mips_cpu_bus_ctrl.sv
// Directed bench for mips_cpu_bus_ctrl. A second instance built with
// FETCH_PRIORITY=1 is used only for the tie-break scenario.
module tb_mips_cpu_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        f_req, d_req, d_we, d_signed, waitrequest;
  logic [31:0] f_addr, d_addr, d_wdata, readdata;
  logic [1:0]  d_size;
  logic        f_ack, d_ack, d_err, busy, read, write;
  logic [31:0] f_rdata, d_rdata, address, writedata;
  logic [3:0]  byteenable;

  logic        p_f_req, p_d_req;
  logic        p_f_ack, p_d_ack, p_d_err, p_busy, p_read, p_write;
  logic [31:0] p_f_rdata, p_d_rdata, p_address, p_writedata;
  logic [3:0]  p_byteenable;

  mips_cpu_bus_ctrl #(.FETCH_PRIORITY(0)) u_dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
    .d_signed(d_signed), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .d_err(d_err), .busy(busy), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  mips_cpu_bus_ctrl #(.FETCH_PRIORITY(1)) u_dut_fp (
    .clk(clk), .rst(rst),
    .f_req(p_f_req), .f_addr(f_addr), .f_ack(p_f_ack), .f_rdata(p_f_rdata),
    .d_req(p_d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
    .d_signed(d_signed), .d_wdata(d_wdata), .d_ack(p_d_ack), .d_rdata(p_d_rdata),
    .d_err(p_d_err), .busy(p_busy), .address(p_address), .read(p_read), .write(p_write),
    .writedata(p_writedata), .byteenable(p_byteenable),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  int vec_count  = 0;
  int miss_count = 0;

  // Observations gathered by run_xfer for the calling test to judge.
  int          ob_strobes, ob_first, ob_ack;
  logic        ob_read, ob_write, ob_stable, ob_busy_ok, ob_dual, ob_err, ob_idle_after;
  logic [31:0] ob_addr, ob_wd, ob_rdata;
  logic [3:0]  ob_be;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request from cycle 0 and records what the bus and ack show.
  task automatic run_xfer(input bit is_f, input bit we, input logic [31:0] addr,
                          input logic [1:0] size, input bit sgn, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits);
    int cyc = 0;
    ob_strobes = 0; ob_first = -1; ob_ack = -1;
    ob_stable = 1'b1; ob_busy_ok = 1'b1; ob_dual = 1'b0; ob_err = 1'b0;
    ob_read = 1'b0; ob_write = 1'b0; ob_addr = '0; ob_wd = '0; ob_be = '0; ob_rdata = '0;
    readdata = rd;
    waitrequest = 1'b0;
    if (is_f) begin
      f_req = 1'b1; f_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_signed = sgn; d_wdata = wd;
    end
    while (ob_ack < 0 && cyc < 40) begin
      tick();
      cyc++;
      waitrequest = (cyc <= waits);
      if (busy !== 1'b1) ob_busy_ok = 1'b0;
      if (read === 1'b1 && write === 1'b1) ob_dual = 1'b1;
      if (read === 1'b1 || write === 1'b1) begin
        ob_strobes++;
        if (ob_first < 0) begin
          ob_first = cyc; ob_read = read; ob_write = write;
          ob_addr = address; ob_wd = writedata; ob_be = byteenable;
        end else if ({read, write, address, writedata, byteenable} !==
                     {ob_read, ob_write, ob_addr, ob_wd, ob_be}) begin
          ob_stable = 1'b0;
        end
      end
      if ((is_f ? f_ack : d_ack) === 1'b1) begin
        ob_ack = cyc;
        ob_rdata = is_f ? f_rdata : d_rdata;
        ob_err = d_err;
      end
    end
    f_req = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
    tick();
    ob_idle_after = (busy === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    f_req = 0; d_req = 0; d_we = 0; d_signed = 0; waitrequest = 0;
    f_addr = '0; d_addr = '0; d_wdata = '0; d_size = 2'b00; readdata = '0;
    p_f_req = 0; p_d_req = 0;
    tick(); tick();
    vec_count++;
    if ({read, write, f_ack, d_ack, d_err, busy, address, writedata, byteenable, f_rdata, d_rdata} !== '0) begin
      miss_count++;
      $display("FAIL reset_outputs: got addr=%h wd=%h be=%b rd=%b wr=%b busy=%b, required all 0",
               address, writedata, byteenable, read, write, busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    run_xfer(1'b1, 1'b0, 32'hBFC0_0000, 2'b10, 1'b0, '0, 32'h2402_0005, 0);
    vec_count++;
    if ({ob_read, ob_write} !== 2'b10 || ob_first != 1) begin miss_count++;
      $display("FAIL fetch_strobe: got rd=%b wr=%b at cycle %0d, required rd=1 wr=0 at cycle 1", ob_read, ob_write, ob_first); end
    vec_count++;
    if (ob_addr !== 32'hBFC0_0000 || ob_be !== 4'b1111) begin miss_count++;
      $display("FAIL fetch_addr_be: got %h/%b, required bfc00000/1111", ob_addr, ob_be); end
    vec_count++;
    if (ob_ack != 2 || ob_rdata !== 32'h2402_0005) begin miss_count++;
      $display("FAIL fetch_ack: got cycle %0d data %h, required cycle 2 data 24020005", ob_ack, ob_rdata); end
    vec_count++;
    if (!ob_busy_ok || !ob_idle_after) begin miss_count++;
      $display("FAIL fetch_busy: got in_flight_ok=%b idle_after=%b, required 1/1", ob_busy_ok, ob_idle_after); end
  endtask

  task automatic test_store_wait();
    run_xfer(1'b0, 1'b1, 32'h0000_1004, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 3);
    vec_count++;
    if (ob_strobes != 4 || !ob_stable || ob_dual) begin miss_count++;
      $display("FAIL sw_hold: got %0d strobe cycles stable=%b dual=%b, required 4/1/0", ob_strobes, ob_stable, ob_dual); end
    vec_count++;
    if ({ob_read, ob_write} !== 2'b01 || ob_addr !== 32'h0000_1004 || ob_wd !== 32'hDEAD_BEEF || ob_be !== 4'b1111) begin
      miss_count++;
      $display("FAIL sw_bus: got rw=%b%b addr=%h wd=%h be=%b, required 01 00001004 deadbeef 1111",
               ob_read, ob_write, ob_addr, ob_wd, ob_be); end
    vec_count++;
    if (ob_ack != 5 || ob_rdata !== 32'h0 || ob_err !== 1'b0) begin miss_count++;
      $display("FAIL sw_ack: got cycle %0d rdata %h err %b, required cycle 5 rdata 0 err 0", ob_ack, ob_rdata, ob_err); end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp;   // writedata for stores, d_rdata for loads
  } vec_t;

  task automatic test_lanes();
    vec_t tbl[9];
    tbl[0] = '{1'b0, 32'h1003, 2'b00, 1'b1, 32'h0,        32'h8011_2233, 32'h1000, 4'b1000, 32'hFFFF_FF80};
    tbl[1] = '{1'b0, 32'h1003, 2'b00, 1'b0, 32'h0,        32'h8011_2233, 32'h1000, 4'b1000, 32'h0000_0080};
    tbl[2] = '{1'b0, 32'h1002, 2'b01, 1'b0, 32'h0,        32'h8011_2233, 32'h1000, 4'b1100, 32'h0000_8011};
    tbl[3] = '{1'b0, 32'h1000, 2'b01, 1'b1, 32'h0,        32'h1234_ABCD, 32'h1000, 4'b0011, 32'hFFFF_ABCD};
    tbl[4] = '{1'b0, 32'h1000, 2'b00, 1'b1, 32'h0,        32'h1234_AB7F, 32'h1000, 4'b0001, 32'h0000_007F};
    tbl[5] = '{1'b0, 32'h1002, 2'b00, 1'b0, 32'h0,        32'h8011_2233, 32'h1000, 4'b0100, 32'h0000_0011};
    tbl[6] = '{1'b0, 32'h1004, 2'b11, 1'b1, 32'h0,        32'hCAFE_F00D, 32'h1004, 4'b1111, 32'hCAFE_F00D};
    tbl[7] = '{1'b1, 32'h1001, 2'b00, 1'b0, 32'h0000_00AB, 32'h0,        32'h1000, 4'b0010, 32'hABAB_ABAB};
    tbl[8] = '{1'b1, 32'h1002, 2'b01, 1'b0, 32'h0000_1234, 32'h0,        32'h1000, 4'b1100, 32'h1234_1234};
    for (int i = 0; i < 9; i++) begin
      run_xfer(1'b0, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].sgn, tbl[i].wd, tbl[i].rd, i % 2);
      vec_count++;
      if (ob_be !== tbl[i].exp_be || ob_addr !== tbl[i].exp_addr || {ob_read, ob_write} !== {!tbl[i].we, tbl[i].we}) begin
        miss_count++;
        $display("FAIL lanes[%0d]_bus: got be=%b addr=%h rw=%b%b, required be=%b addr=%h we=%b",
                 i, ob_be, ob_addr, ob_read, ob_write, tbl[i].exp_be, tbl[i].exp_addr, tbl[i].we); end
      vec_count++;
      if ((tbl[i].we ? ob_wd : ob_rdata) !== tbl[i].exp || ob_ack != 2 + (i % 2)) begin
        miss_count++;
        $display("FAIL lanes[%0d]_data: got %h at cycle %0d, required %h at cycle %0d",
                 i, tbl[i].we ? ob_wd : ob_rdata, ob_ack, tbl[i].exp, 2 + (i % 2)); end
    end
  endtask

  task automatic test_misaligned();
    run_xfer(1'b0, 1'b0, 32'h0000_1002, 2'b10, 1'b0, '0, 32'h8011_2233, 0);
`ifdef MIPS_BUS_ALIGN_CHECK_EN
    vec_count++;
    if (ob_strobes != 0 || ob_ack != 1 || ob_err !== 1'b1 || ob_rdata !== 32'h0) begin miss_count++;
      $display("FAIL lw_misaligned: got strobes=%0d ack_cycle=%0d err=%b rdata=%h, required 0/1/1/0",
               ob_strobes, ob_ack, ob_err, ob_rdata); end
`else
    vec_count++;
    if ({ob_read, ob_write} !== 2'b10 || ob_addr !== 32'h0000_1000 || ob_be !== 4'b1111 ||
        ob_ack != 2 || ob_rdata !== 32'h8011_2233 || ob_err !== 1'b0) begin miss_count++;
      $display("FAIL lw_unaligned: got rw=%b%b addr=%h be=%b ack_cycle=%0d rdata=%h err=%b, required 10 00001000 1111 2 80112233 0",
               ob_read, ob_write, ob_addr, ob_be, ob_ack, ob_rdata, ob_err); end
`endif
    run_xfer(1'b0, 1'b0, 32'h0000_1003, 2'b01, 1'b0, '0, 32'h8011_2233, 0);
`ifdef MIPS_BUS_ALIGN_CHECK_EN
    vec_count++;
    if (ob_strobes != 0 || ob_ack != 1 || ob_err !== 1'b1) begin miss_count++;
      $display("FAIL lh_misaligned: got strobes=%0d ack_cycle=%0d err=%b, required 0/1/1", ob_strobes, ob_ack, ob_err); end
`else
    vec_count++;
    if (ob_be !== 4'b1100 || ob_rdata !== 32'h0000_8011 || ob_err !== 1'b0) begin miss_count++;
      $display("FAIL lh_unaligned: got be=%b rdata=%h err=%b, required 1100 00008011 0", ob_be, ob_rdata, ob_err); end
`endif
  endtask

  task automatic test_arbitration();
    int cyc = 0;
    int dack = -1, fack = -1, p_dack = -1, p_fack = -1;
    f_addr = 32'h0000_0100; d_we = 1'b0; d_addr = 32'h0000_2000; d_size = 2'b10; d_signed = 1'b0;
    readdata = 32'h1111_2222; waitrequest = 1'b0;
    f_req = 1'b1; d_req = 1'b1; p_f_req = 1'b1; p_d_req = 1'b1;
    while (cyc < 12) begin
      tick();
      cyc++;
      if (d_ack === 1'b1)   begin dack = cyc;   d_req = 1'b0;   end
      if (f_ack === 1'b1)   begin fack = cyc;   f_req = 1'b0;   end
      if (p_d_ack === 1'b1) begin p_dack = cyc; p_d_req = 1'b0; end
      if (p_f_ack === 1'b1) begin p_fack = cyc; p_f_req = 1'b0; end
    end
    f_req = 1'b0; d_req = 1'b0; p_f_req = 1'b0; p_d_req = 1'b0;
    vec_count++;
    if (dack != 2 || fack != 5) begin miss_count++;
      $display("FAIL tie_data_first: got d_ack %0d f_ack %0d, required 2 and 5", dack, fack); end
    vec_count++;
    if (p_fack != 2 || p_dack != 5) begin miss_count++;
      $display("FAIL tie_fetch_first: got f_ack %0d d_ack %0d, required 2 and 5", p_fack, p_dack); end
  endtask

  task automatic test_reset_stall();
    logic stray_ack = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_3008; d_size = 2'b10; d_wdata = 32'h55AA_33CC;
    waitrequest = 1'b0;
    tick();
    waitrequest = 1'b1;
    vec_count++;
    if (write !== 1'b1 || address !== 32'h0000_3008) begin miss_count++;
      $display("FAIL stall_start: got write=%b addr=%h, required 1 00003008", write, address); end
    tick();
    rst = 1'b1; d_req = 1'b0;
    tick();
    vec_count++;
    if ({read, write, f_ack, d_ack, d_err, busy, address, writedata, byteenable, f_rdata, d_rdata} !== '0) begin
      miss_count++;
      $display("FAIL stall_reset: got addr=%h wd=%h be=%b wr=%b busy=%b f_rdata=%h d_rdata=%h, required all 0",
               address, writedata, byteenable, write, busy, f_rdata, d_rdata); end
    rst = 1'b0; waitrequest = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (d_ack !== 1'b0 || f_ack !== 1'b0 || busy !== 1'b0) stray_ack = 1'b1;
    end
    vec_count++;
    if (stray_ack) begin miss_count++;
      $display("FAIL stall_no_ack: got ack or busy after reset, required none"); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_wait();
    test_lanes();
    test_misaligned();
    test_arbitration();
    test_reset_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
